// File: rtl/mult_pkg.sv
// Shared constants and helpers for the shift-adder multiplier front stage and adder tree wrapper.
package mult_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  localparam int MULT_WIDTH      = 8;
  localparam int MULT_PP_WIDTH   = 2 * MULT_WIDTH;
  localparam int MULT_TREE_DEPTH = clog2(MULT_WIDTH);
  localparam int MULT_TAG_WIDTH  = 4;

  typedef logic [MULT_TAG_WIDTH-1:0] tag_t;

endpackage

// File: rtl/pp_valid_delay.sv
// Shift register with synchronous clear; carries {valid, tag} alongside the adder tree.
module pp_valid_delay #(
  parameter int DEPTH = 3,
  parameter int DW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DEPTH-1:0][DW-1:0] stages;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else if (clear) begin
      stages <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/mult_pp_gen.sv
// Partial-product generator feeding the first adder_layer; tracks valid/tag alongside the tree.
module mult_pp_gen
  import mult_pkg::*;
#(
  parameter int WIDTH      = MULT_WIDTH,
  parameter int PP_WIDTH   = 2 * WIDTH,
  parameter int TREE_DEPTH = clog2(WIDTH),
  parameter int TAG_WIDTH  = MULT_TAG_WIDTH,
  parameter int IW         = clog2(TREE_DEPTH + 2)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      din_valid,
  input  logic [WIDTH-1:0]          din_a,
  input  logic [WIDTH-1:0]          din_b,
  input  logic                      flush,
  output logic [WIDTH*PP_WIDTH-1:0] pp_dout,
  output logic                      pp_valid,
  output logic                      result_valid,
  output logic [TAG_WIDTH-1:0]      result_tag,
  output logic [IW-1:0]             inflight
);

  logic [WIDTH*PP_WIDTH-1:0] pp_next;
  logic [TAG_WIDTH-1:0]      tag_cnt;
  logic [TAG_WIDTH-1:0]      pp_tag;
  logic                      capture;
  logic                      leaving;

  assign capture = din_valid && !flush;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pp
      assign pp_next[gi*PP_WIDTH +: PP_WIDTH] =
        din_b[gi] ? (PP_WIDTH'(din_a) << gi) : {PP_WIDTH{1'b0}};
    end
  endgenerate

  // Idle and flushed cycles drive zeros so the tree keeps summing zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp_dout  <= '0;
      pp_valid <= 1'b0;
      pp_tag   <= '0;
      tag_cnt  <= '0;
    end else if (capture) begin
      pp_dout  <= pp_next;
      pp_valid <= 1'b1;
      pp_tag   <= tag_cnt;
      tag_cnt  <= tag_cnt + 1'b1;
    end else begin
      pp_dout  <= '0;
      pp_valid <= 1'b0;
      pp_tag   <= '0;
    end
  end

  pp_valid_delay #(
    .DEPTH (TREE_DEPTH),
    .DW    (TAG_WIDTH + 1)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .din   ({pp_valid, pp_tag}),
    .dout  ({result_valid, result_tag})
  );

  // The oldest valid leaves the tracked window at the next edge.
  assign leaving = result_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (flush) begin
      inflight <= '0;
    end else begin
      inflight <= inflight + IW'(capture) - IW'(leaving);
    end
  end

endmodule

// File: tb/tb_mult_pp_gen.sv
// Directed bench for mult_pp_gen with a behavioural three-level adder tree downstream.
module tb_mult_pp_gen;
  import mult_pkg::*;

  localparam int W  = 8;
  localparam int PW = 16;

  logic             clk;
  logic             rst_n;
  logic             din_valid;
  logic [W-1:0]     din_a;
  logic [W-1:0]     din_b;
  logic             flush;
  logic [W*PW-1:0]  pp_dout;
  logic             pp_valid;
  logic             result_valid;
  logic [3:0]       result_tag;
  logic [2:0]       inflight;

  mult_pp_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din_valid    (din_valid),
    .din_a        (din_a),
    .din_b        (din_b),
    .flush        (flush),
    .pp_dout      (pp_dout),
    .pp_valid     (pp_valid),
    .result_valid (result_valid),
    .result_tag   (result_tag),
    .inflight     (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream adder tree: three 1-cycle layers.
  logic [18:0] s1 [4];
  logic [18:0] s2 [2];
  logic [18:0] s3;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 4; j++) s1[j] <= '0;
      s2[0] <= '0;
      s2[1] <= '0;
      s3    <= '0;
    end else begin
      for (int j = 0; j < 4; j++)
        s1[j] <= 19'(pp_dout[(2*j)*PW +: PW]) + 19'(pp_dout[(2*j+1)*PW +: PW]);
      s2[0] <= s1[0] + s1[1];
      s2[1] <= s1[2] + s1[3];
      s3    <= s2[0] + s2[1];
    end
  end

  int checks;
  int failures;
  logic [19:0] exp_q[$];
  tag_t exp_tag;
  logic mon_en;
  int rv_cycles, rv_rises, infl_max;
  logic prev_rv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result_valid", 32'(result_valid), 32'd0);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          chk("result_tag", 32'(result_tag), 32'(e[19:16]));
          chk("result_sum", 32'(s3[15:0]), 32'(e[15:0]));
          chk("result_sum_upper", 32'(s3[18:16]), 32'd0);
        end
      end
      if (result_valid && !prev_rv) rv_rises++;
      if (result_valid) rv_cycles++;
      if (32'(inflight) > infl_max) infl_max = 32'(inflight);
      prev_rv = result_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    exp_q.push_back({exp_tag, p});
    exp_tag = exp_tag + 1'b1;
  endtask

  task automatic cap(input logic [W-1:0] a, input logic [W-1:0] b);
    din_valid = 1'b1;
    din_a = a;
    din_b = b;
    push_exp(a, b);
    step();
    din_valid = 1'b0;
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    flush = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    exp_q.delete();
    exp_tag = '0;
    rst_n = 1'b1;
    step();
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [15:0]  prod;
  } vec_t;

  vec_t vecs [6];
  int lat;

  initial begin
    checks = 0;
    failures = 0;
    mon_en = 1'b0;
    prev_rv = 1'b0;
    rv_cycles = 0;
    rv_rises = 0;
    infl_max = 0;
    exp_tag = '0;
    din_valid = 1'b0;
    din_a = '0;
    din_b = '0;
    flush = 1'b0;
    rst_n = 1'b0;

    vecs[0] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{8'h12, 8'h00, 16'h0000};
    vecs[2] = '{8'h00, 8'h5A, 16'h0000};
    vecs[3] = '{8'h01, 8'h80, 16'h0080};
    vecs[4] = '{8'h80, 8'h80, 16'h4000};
    vecs[5] = '{8'hA5, 8'h3C, 16'h26AC};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_pp_dout", 32'(pp_dout != '0), 32'd0);
    chk("reset_pp_valid", 32'(pp_valid), 32'd0);
    chk("reset_result_valid", 32'(result_valid), 32'd0);
    chk("reset_result_tag", 32'(result_tag), 32'd0);
    chk("reset_inflight", 32'(inflight), 32'd0);
    mon_en = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      cap(vecs[i].a, vecs[i].b);
      @(negedge clk);
      chk("vec_pp_valid", 32'(pp_valid), 32'd1);
      chk("vec_inflight", 32'(inflight), 32'd1);
      for (int k = 0; k < W; k++) begin
        logic [15:0] ew;
        ew = vecs[i].b[k] ? (16'(vecs[i].a) << k) : 16'h0;
        chk($sformatf("vec%0d_pp_word%0d", i, k), 32'(pp_dout[k*PW +: PW]), 32'(ew));
      end
      lat = 1;
      while (!result_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      chk("vec_latency", 32'(lat), 32'd4);
      step();
      step();
    end

    do_reset();
    rv_cycles = 0;
    rv_rises = 0;
    infl_max = 0;
    for (int n = 0; n < 20; n++) begin
      din_valid = 1'b1;
      din_a = W'($urandom_range(0, 255));
      din_b = W'($urandom_range(0, 255));
      push_exp(din_a, din_b);
      step();
    end
    din_valid = 1'b0;
    repeat (8) step();
    chk("b2b_result_cycles", 32'(rv_cycles), 32'd20);
    chk("b2b_contiguous", 32'(rv_rises), 32'd1);
    chk("b2b_inflight_max", 32'(infl_max), 32'd4);

    do_reset();
    din_valid = 1'b1; din_a = 8'h11; din_b = 8'h22; push_exp(din_a, din_b); step();
    din_valid = 1'b1; din_a = 8'h33; din_b = 8'h44; push_exp(din_a, din_b); step();
    din_valid = 1'b1; din_a = 8'h55; din_b = 8'h66; flush = 1'b1; step();
    flush = 1'b0;
    din_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_inflight", 32'(inflight), 32'd0);
    chk("flush_pp_valid", 32'(pp_valid), 32'd0);
    chk("flush_pp_dout", 32'(pp_dout != '0), 32'd0);
    repeat (6) step();
    cap(8'h07, 8'h09);
    repeat (6) step();

    do_reset();
    cap(8'h21, 8'h43);
    cap(8'h65, 8'h87);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_pp_valid", 32'(pp_valid), 32'd0);
    chk("midrst_pp_dout", 32'(pp_dout != '0), 32'd0);
    chk("midrst_inflight", 32'(inflight), 32'd0);
    chk("midrst_result_valid", 32'(result_valid), 32'd0);
    chk("midrst_result_tag", 32'(result_tag), 32'd0);
    exp_q.delete();
    exp_tag = '0;
    step();
    rst_n = 1'b1;
    repeat (5) step();
    cap(8'hC3, 8'h5E);
    lat = 1;
    @(negedge clk);
    while (!result_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("midrst_latency", 32'(lat), 32'd4);
    repeat (6) step();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
